// File: rtl/jtag_dmi_pkg.sv
// Shared DMI constants and arbiter state type for the JTAG DMI arbiter slice.
package jtag_dmi_pkg;

    localparam int DMI_ADDR_WIDTH = 7;
    localparam int DMI_DATA_WIDTH = 32;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } dmi_arb_state_e;

    function automatic logic [1:0] port_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/jtag_dmi_rr_arb.sv
// Two-way round-robin grant: a tie goes to the port that did not win last.
module jtag_dmi_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic       update,
    input  logic       update_id,
    output logic       grant_valid,
    output logic       grant_id
);

    logic last_grant_q;

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (update) begin
            last_grant_q <= update_id;
        end
    end

    always_comb begin
        grant_valid = |req_valid;
        if (&req_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

endmodule

// File: rtl/jtag_dmi_arbiter.sv
// Shares one Debug Module DMI port between the JTAG DTM (port 0) and a bus bridge (port 1).
// Optional ISSUE/WAIT abort counter enabled by defining JTAG_DMI_ARB_TIMEOUT_EN.
module jtag_dmi_arbiter
    import jtag_dmi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [1:0][DMI_ADDR_WIDTH-1:0]       req_addr,
    input  logic [1:0][DMI_DATA_WIDTH-1:0]       req_wdata,
    input  logic [1:0][1:0]                      req_op,
    output logic [1:0]                           rsp_valid,
    output logic [DMI_DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                           rsp_resp,
    output logic                                 dm_req_valid,
    input  logic                                 dm_req_ready,
    output logic [DMI_ADDR_WIDTH-1:0]            dm_addr,
    output logic [DMI_DATA_WIDTH-1:0]            dm_wdata,
    output logic [1:0]                           dm_op,
    input  logic                                 dm_rsp_valid,
    input  logic [DMI_DATA_WIDTH-1:0]            dm_rdata,
    input  logic [1:0]                           dm_resp,
    output logic                                 busy,
    output logic                                 grant_id
);

    dmi_arb_state_e state_q, state_d;

    logic                      win_valid;
    logic                      win_id;
    logic                      accept;
    logic                      latch_dm;
    logic                      load_rsp;
    logic [DMI_DATA_WIDTH-1:0] rsp_rdata_d;
    logic [1:0]                rsp_resp_d;
    logic                      timeout_hit;

    logic                      id_q;
    logic [DMI_ADDR_WIDTH-1:0] addr_q;
    logic [DMI_DATA_WIDTH-1:0] wdata_q;
    logic [1:0]                op_q;
    logic [DMI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                resp_q;

    jtag_dmi_rr_arb u_rr_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .update      (state_q == RESP),
        .update_id   (id_q),
        .grant_valid (win_valid),
        .grant_id    (win_id)
    );

`ifdef JTAG_DMI_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ISSUE || state_q == WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
        end
    end

    // Counter reads 0 in the first ISSUE cycle, so the abort lands on the
    // TIMEOUT_CYCLES-th cycle spent in ISSUE+WAIT.
    assign timeout_hit = (state_q == ISSUE || state_q == WAIT) &&
                         (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_W};
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        rsp_valid    = '0;
        dm_req_valid = 1'b0;
        accept       = 1'b0;
        latch_dm     = 1'b0;
        load_rsp     = 1'b0;
        rsp_rdata_d  = '0;
        rsp_resp_d   = DMI_RESP_SUCCESS;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    accept    = 1'b1;
                    req_ready = port_onehot(win_id);
                    if (req_op[win_id] == DMI_OP_READ || req_op[win_id] == DMI_OP_WRITE) begin
                        latch_dm = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        load_rsp   = 1'b1;
                        rsp_resp_d = (req_op[win_id] == DMI_OP_NOP) ? DMI_RESP_SUCCESS
                                                                    : DMI_RESP_FAILED;
                        state_d    = RESP;
                    end
                end
            end
            ISSUE: begin
                dm_req_valid = 1'b1;
                if (dm_req_ready && dm_rsp_valid) begin
                    load_rsp    = 1'b1;
                    rsp_rdata_d = dm_rdata;
                    rsp_resp_d  = dm_resp;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    load_rsp   = 1'b1;
                    rsp_resp_d = DMI_RESP_FAILED;
                    state_d    = RESP;
                end else if (dm_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dm_rsp_valid) begin
                    load_rsp    = 1'b1;
                    rsp_rdata_d = dm_rdata;
                    rsp_resp_d  = dm_resp;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    load_rsp   = 1'b1;
                    rsp_resp_d = DMI_RESP_FAILED;
                    state_d    = RESP;
                end
            end
            RESP: begin
                rsp_valid = port_onehot(id_q);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q <= win_id;
            end
            if (latch_dm) begin
                addr_q  <= req_addr[win_id];
                wdata_q <= req_wdata[win_id];
                op_q    <= req_op[win_id];
            end
            // Response registers change only on entry to RESP and hold afterwards.
            if (load_rsp) begin
                rdata_q <= rsp_rdata_d;
                resp_q  <= rsp_resp_d;
            end
        end
    end

    assign dm_addr   = addr_q;
    assign dm_wdata  = wdata_q;
    assign dm_op     = op_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = id_q;

endmodule
